// File: rtl/tracklet_pkg.sv
// Shared defaults, word field positions and FSM encoding for the VM
// projection/stub tracklet matching stages.
package tracklet_pkg;

  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_DATA_W  = 13;
  localparam int DEF_PHI_W   = 6;
  localparam int DEF_PHI_WIN = 2;
  localparam int DEF_Z_WIN   = 3;

  // Phi occupies the top bits of a VM word; z fills the rest.
  localparam int PHI_MSB = DEF_DATA_W - 1;
  localparam int PHI_LSB = DEF_DATA_W - DEF_PHI_W;
  localparam int Z_MSB   = PHI_LSB - 1;
  localparam int Z_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vm_window_compare.sv
// Combinational phi/z window test between one projection word and one stub word.
module vm_window_compare
  import tracklet_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int P_MSB   = PHI_MSB,
  parameter int P_LSB   = PHI_LSB,
  parameter int ZF_MSB  = Z_MSB,
  parameter int ZF_LSB  = Z_LSB,
  parameter int PHI_WIN = DEF_PHI_WIN,
  parameter int Z_WIN   = DEF_Z_WIN
) (
  input  logic [DATA_W-1:0] proj,
  input  logic [DATA_W-1:0] stub,
  output logic              hit
);

  localparam int PW = P_MSB - P_LSB + 1;
  localparam int ZW = ZF_MSB - ZF_LSB + 1;

  // One extra bit on every operand keeps the difference from wrapping.
  logic [PW:0] proj_phi, stub_phi, dphi;
  logic [ZW:0] proj_z, stub_z, dz;

  always_comb begin
    proj_phi = {1'b0, proj[P_MSB:P_LSB]};
    stub_phi = {1'b0, stub[P_MSB:P_LSB]};
    proj_z   = {1'b0, proj[ZF_MSB:ZF_LSB]};
    stub_z   = {1'b0, stub[ZF_MSB:ZF_LSB]};
    dphi     = (proj_phi >= stub_phi) ? proj_phi - stub_phi : stub_phi - proj_phi;
    dz       = (proj_z >= stub_z) ? proj_z - stub_z : stub_z - proj_z;
    hit      = (dphi <= (PW+1)'(PHI_WIN)) && (dz <= (ZW+1)'(Z_WIN));
  end

endmodule

// File: rtl/vm_proj_match_engine.sv
// Walks every VM projection against every VM stub and writes the pairs that
// fall inside the phi/z window into the match memory.
module vm_proj_match_engine
  import tracklet_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PHI_W   = DEF_PHI_W,
  parameter int PHI_WIN = DEF_PHI_WIN,
  parameter int Z_WIN   = DEF_Z_WIN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_proc,
  input  logic [ADDR_W-1:0]   nproj,
  input  logic [ADDR_W-1:0]   nstub,
  output logic [ADDR_W-1:0]   read_proj,
  input  logic [DATA_W-1:0]   projection,
  output logic [ADDR_W-1:0]   read_stub,
  input  logic [DATA_W-1:0]   stub,
  output logic                match_wr_en,
  output logic [ADDR_W-1:0]   match_wr_add,
  output logic [2*ADDR_W-1:0] match_out,
  output logic [ADDR_W-1:0]   nmatch,
  output logic                overflow,
  output logic                busy,
  output logic                done
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   nproj_r, nstub_r;
  logic [DATA_W-1:0]   proj_reg;
  logic                s1_v;
  logic [ADDR_W-1:0]   s1_p, s1_j;
  logic                drain_second;
  logic                hit, last_proj, last_stub;

  // read_proj / read_stub double as the p / j loop counters.
  assign last_proj = (read_proj == nproj_r - ADDR_W'(1));
  assign last_stub = (read_stub == nstub_r - ADDR_W'(1));

  vm_window_compare #(
    .DATA_W (DATA_W),
    .P_MSB  (DATA_W - 1),
    .P_LSB  (DATA_W - PHI_W),
    .ZF_MSB (DATA_W - PHI_W - 1),
    .ZF_LSB (0),
    .PHI_WIN(PHI_WIN),
    .Z_WIN  (Z_WIN)
  ) u_cmp (
    .proj(proj_reg),
    .stub(stub),
    .hit (hit)
  );

  // NOTE: every register in this block uses non-blocking assignment so all
  // state updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (en_proc) state_n = (nproj == '0) ? ST_DRAIN : ST_LOAD;
      ST_LOAD:  if (nstub_r != '0) state_n = ST_SCAN;
                else               state_n = last_proj ? ST_DRAIN : ST_LOAD;
      ST_SCAN:  if (last_stub)     state_n = last_proj ? ST_DRAIN : ST_LOAD;
      ST_DRAIN: if (drain_second)  state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // NOTE: every register is reset, including the pipeline payload, so that a
  // mid-event reset leaves all outputs at zero on the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      nproj_r      <= '0;
      nstub_r      <= '0;
      read_proj    <= '0;
      read_stub    <= '0;
      proj_reg     <= '0;
      s1_v         <= 1'b0;
      s1_p         <= '0;
      s1_j         <= '0;
      drain_second <= 1'b0;
      match_wr_en  <= 1'b0;
      match_wr_add <= '0;
      match_out    <= '0;
      nmatch       <= '0;
      overflow     <= 1'b0;
    end else begin
      s1_v         <= (state == ST_SCAN);
      s1_p         <= read_proj;
      s1_j         <= read_stub;
      drain_second <= (state == ST_DRAIN) && !drain_second;
      match_wr_en  <= 1'b0;

      unique case (state)
        ST_IDLE: if (en_proc) begin
          nproj_r  <= nproj;
          nstub_r  <= nstub;
          nmatch   <= '0;
          overflow <= 1'b0;
          if (nproj != '0) read_proj <= '0;
        end
        ST_LOAD: begin
          if (nstub_r != '0)   read_stub <= '0;
          else if (!last_proj) read_proj <= read_proj + ADDR_W'(1);
        end
        ST_SCAN: begin
          if (read_stub == '0) proj_reg <= projection;
          if (!last_stub)      read_stub <= read_stub + ADDR_W'(1);
          else if (!last_proj) read_proj <= read_proj + ADDR_W'(1);
        end
        default: ;
      endcase

      // The last match-memory slot stays unused so nmatch never wraps.
      if (s1_v && hit) begin
        if (nmatch != '1) begin
          match_wr_en  <= 1'b1;
          match_wr_add <= nmatch;
          match_out    <= {s1_p, s1_j};
          nmatch       <= nmatch + ADDR_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vm_proj_match_engine.sv
// Self-checking bench for vm_proj_match_engine: directed scenarios plus
// randomized events against a pair-enumerating reference model.
module tb_vm_proj_match_engine;

  localparam int AW  = 9;
  localparam int DW  = 13;
  localparam int CAP = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            reset, en_proc;
  logic [AW-1:0]   nproj, nstub, read_proj, read_stub, match_wr_add, nmatch;
  logic [DW-1:0]   projection, stub;
  logic            match_wr_en, overflow, busy, done;
  logic [2*AW-1:0] match_out;

  logic [DW-1:0]   proj_mem [1 << AW];
  logic [DW-1:0]   stub_mem [1 << AW];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Synchronous memories with one cycle of read latency.
  always @(posedge clk) begin
    projection <= proj_mem[read_proj];
    stub       <= stub_mem[read_stub];
  end

  vm_proj_match_engine dut (
    .clk         (clk),
    .reset       (reset),
    .en_proc     (en_proc),
    .nproj       (nproj),
    .nstub       (nstub),
    .read_proj   (read_proj),
    .projection  (projection),
    .read_stub   (read_stub),
    .stub        (stub),
    .match_wr_en (match_wr_en),
    .match_wr_add(match_wr_add),
    .match_out   (match_out),
    .nmatch      (nmatch),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input int phi, input int z);
    return {6'(phi), 7'(z)};
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit pair_hit(input logic [DW-1:0] pw, input logic [DW-1:0] sw);
    return absdiff(int'(pw[12:7]), int'(sw[12:7])) <= 2 &&
           absdiff(int'(pw[6:0]),  int'(sw[6:0]))  <= 3;
  endfunction

  // Runs one event starting with en_proc sampled in cycle 0. poke re-asserts
  // en_proc while busy; abort_at > 0 asserts reset in that cycle.
  task automatic run_event(input int np, input int ns, input bit poke, input int abort_at);
    int exp_p[$];
    int exp_j[$];
    int total = 0;
    int done_cyc, lim, cyc, wr_idx, extra;
    bit seen_done = 1'b0;
    bit aborted = 1'b0;
    logic [2*AW-1:0] exp_word;

    for (int p = 0; p < np; p++)
      for (int j = 0; j < ns; j++)
        if (pair_hit(proj_mem[p], stub_mem[j])) begin
          total++;
          if (exp_p.size() < CAP) begin
            exp_p.push_back(p);
            exp_j.push_back(j);
          end
        end
    done_cyc = (np == 0) ? 3 : 1 + np * (1 + ns) + 2;
    lim      = done_cyc + 10;
    cyc      = 0;
    wr_idx   = 0;

    @(negedge clk);
    nproj   = AW'(np);
    nstub   = AW'(ns);
    en_proc = 1'b1;
    while (!seen_done && !aborted && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        en_proc = 1'b0;
        nproj   = AW'($urandom);
        nstub   = AW'($urandom);
        check("busy_after_start", busy, 1'b1);
      end
      if (poke) en_proc = (cyc == 3);
      if (match_wr_en) begin
        if (wr_idx < exp_p.size()) begin
          exp_word = {AW'(exp_p[wr_idx]), AW'(exp_j[wr_idx])};
          check("wr_addr", match_wr_add, wr_idx);
          check("wr_data", match_out, exp_word);
          check("wr_cycle", cyc, exp_p[wr_idx] * (1 + ns) + exp_j[wr_idx] + 4);
        end else begin
          check("extra_write", wr_idx, exp_p.size());
        end
        wr_idx++;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, done_cyc);
        check("nmatch", nmatch, exp_p.size());
        check("overflow", overflow, total > CAP);
        check("write_count", wr_idx, exp_p.size());
      end
      if (abort_at > 0 && cyc == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs",
              {busy, match_wr_en, done, overflow, nmatch, read_proj, read_stub,
               match_wr_add, match_out}, '0);
        reset   = 1'b0;
        aborted = 1'b1;
      end
    end
    if (!aborted) begin
      check("done_seen", seen_done, 1'b1);
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (done || busy || match_wr_en) extra++;
      end
      check("quiet_after_done", extra, 0);
    end
  endtask

  initial begin
    logic [2*AW-1:0] addr_before;

    reset   = 1'b1;
    en_proc = 1'b0;
    nproj   = '0;
    nstub   = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      proj_mem[i] = '0;
      stub_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, match_wr_en, done, overflow, nmatch, read_proj, read_stub,
           match_wr_add, match_out}, '0);
    reset = 1'b0;

    // Single pair inside the window.
    proj_mem[0] = w(10, 20);
    stub_mem[0] = w(11, 22);
    run_event(1, 1, 1'b0, 0);

    // Phi just outside the window, in both directions.
    stub_mem[0] = w(13, 22);
    run_event(1, 1, 1'b0, 0);
    proj_mem[0] = w(13, 20);
    stub_mem[0] = w(10, 20);
    run_event(1, 1, 1'b0, 0);

    // z window edge: dz=4 misses, dz=3 hits (stub below projection).
    proj_mem[0] = w(10, 25);
    stub_mem[0] = w(10, 21);
    stub_mem[1] = w(12, 22);
    run_event(1, 2, 1'b0, 0);

    // Only projection 1 matches each of the four stubs; en_proc poked while busy.
    proj_mem[0] = w(5, 5);
    proj_mem[1] = w(40, 60);
    proj_mem[2] = w(60, 120);
    stub_mem[0] = w(40, 60);
    stub_mem[1] = w(41, 63);
    stub_mem[2] = w(39, 57);
    stub_mem[3] = w(42, 58);
    run_event(3, 4, 1'b1, 0);

    // No projections: read addresses must not move.
    addr_before = {read_proj, read_stub};
    run_event(0, 5, 1'b0, 0);
    check("no_reads", {read_proj, read_stub}, addr_before);

    // No stubs: only LOAD cycles.
    run_event(2, 0, 1'b0, 0);

    // Every pair matches: memory fills to CAP entries and overflow sets.
    proj_mem[0] = w(30, 40);
    proj_mem[1] = w(31, 41);
    for (int j = 0; j < CAP; j++) stub_mem[j] = w(30, 40);
    run_event(2, CAP, 1'b0, 0);

    // Overflow must clear on the next accepted event.
    proj_mem[0] = w(1, 1);
    stub_mem[0] = w(2, 2);
    run_event(1, 1, 1'b0, 0);

    // Reset in mid-scan, then a fresh run must reproduce the full result.
    proj_mem[0] = w(5, 5);
    proj_mem[1] = w(40, 60);
    proj_mem[2] = w(60, 120);
    stub_mem[0] = w(40, 60);
    stub_mem[1] = w(41, 63);
    stub_mem[2] = w(39, 57);
    stub_mem[3] = w(42, 58);
    run_event(3, 4, 1'b0, 9);
    run_event(3, 4, 1'b0, 0);

    // Randomized events with clustered fields so hits and misses both occur.
    for (int t = 0; t < 8; t++) begin
      int np, ns;
      np = int'($urandom_range(5, 1));
      ns = int'($urandom_range(6, 0));
      for (int i = 0; i < np; i++)
        proj_mem[i] = w(int'($urandom_range(24, 20)), int'($urandom_range(35, 30)));
      for (int i = 0; i < ns; i++)
        stub_mem[i] = w(int'($urandom_range(24, 20)), int'($urandom_range(35, 30)));
      run_event(np, ns, t[0], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vm_proj_match_engine.md
Name: vm_proj_match_engine

Overview:
- Downstream stage of the VM projection router; one instance per VM projection memory.
- On `en_proc`, walks every projection stored in its VM projection memory. For each one, scans every stub in the matching VM stub memory.
- Each (projection, stub) pair that lies inside a phi/z window is written as a candidate match into a match memory.
- Reads go through the standard synchronous `Memory` blocks, which have 1-cycle read latency (`OUT` is valid the cycle after `READ_ADD`).

Parameters:
- ADDR_W, 9, address width of the projection, stub and match memories.
- DATA_W, 13, width of VM projection and VM stub words.
- PHI_W, 6, phi field width. Phi is bits [DATA_W-1 : DATA_W-PHI_W]; z is the remaining low bits.
- PHI_WIN, 2, maximum allowed |proj_phi - stub_phi|, inclusive.
- Z_WIN, 3, maximum allowed |proj_z - stub_z|, inclusive.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en_proc  in  1  start-of-event pulse; sampled only in IDLE.
- nproj  in  ADDR_W  number of valid projections; latched on accepted en_proc.
- nstub  in  ADDR_W  number of valid stubs; latched on accepted en_proc.
- read_proj  out  ADDR_W  VM projection memory read address.
- projection  in  DATA_W  VM projection memory output (1-cycle latency).
- read_stub  out  ADDR_W  VM stub memory read address.
- stub  in  DATA_W  VM stub memory output (1-cycle latency).
- match_wr_en  out  1  match memory write enable.
- match_wr_add  out  ADDR_W  match memory write address.
- match_out  out  2*ADDR_W  match word {proj_index, stub_index}.
- nmatch  out  ADDR_W  matches written this event; valid when done is high.
- overflow  out  1  sticky per event; set if a match is dropped because the memory is full.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  single-cycle pulse at end of event.

Behaviour:
- Reset: state=IDLE; all outputs 0; all counters and pipeline valid bits cleared. This applies mid-event too: reset aborts the event, and no write occurs in the following cycle.
- States: IDLE, LOAD, SCAN, DRAIN, DONE.
- IDLE:
  - en_proc=1 latches nproj and nstub, clears nmatch and overflow.
  - If nproj=0, go to DRAIN; otherwise set p=0 and go to LOAD.
- LOAD (1 cycle):
  - Drive read_proj=p.
  - Next state is SCAN if nstub>0.
  - If nstub=0: increment p; next state is LOAD if p<nproj-1, else DRAIN.
- SCAN (cycle j, j = 0 .. nstub-1):
  - Drive read_stub=j.
  - In j=0, register `projection` (valid this cycle) into proj_reg together with index p.
  - After j=nstub-1: increment p; next state is LOAD if more projections remain, else DRAIN.
- Compare pipeline:
  - Stub data for address j arrives in SCAN cycle j+1 (or the next LOAD/DRAIN cycle).
  - It is compared combinationally against proj_reg using unsigned absolute differences. Each difference is computed one bit wider than its field, so there is no wrap.
  - The result is registered, so match_wr_en is asserted 2 cycles after read_stub=j was driven.
  - The compare stage carries its own copy of {p, j}, so a new proj_reg load in the next LOAD/SCAN cycle does not corrupt in-flight pairs.
- Match condition: |dphi| <= PHI_WIN AND |dz| <= Z_WIN.
- Match write:
  - match_wr_add = nmatch; match_out = {p, j}.
  - nmatch increments after each write.
- Full match memory:
  - Once nmatch = 2^ADDR_W - 1, further matches are not written and nmatch saturates.
  - overflow is set to 1 and holds until the next accepted en_proc.
- DRAIN: 2 cycles, letting the compare pipeline empty; then DONE.
- DONE: done=1 for one cycle; next state IDLE.
- Latency: done is high at cycle 1 + nproj*(1+nstub) + 2 after the cycle en_proc was sampled, or cycle 3 when nproj=0.
- en_proc while busy is ignored. Changes on nproj/nstub after latch are ignored.
- read_proj and read_stub hold their last value when not actively driven. match_wr_en=0 except on a qualified match.

Decomposition:
- Shared package `tracklet_pkg`:
  - field-position constants PHI_MSB, PHI_LSB, Z_MSB, Z_LSB;
  - state encoding localparams;
  - default ADDR_W and DATA_W.
- One natural sub-module: `vm_window_compare`. It is combinational: proj word, stub word, windows -> match bit.
- FSM, counters and pipeline registers stay in the top of this block.

Test Plan:
1. nproj=1, nstub=1; proj phi=10, z=20; stub phi=11, z=22; en_proc at cycle 0 -> one write at cycle 4 (match_wr_add=0, match_out={0,0}); done at cycle 5; nmatch=1.
2. Same as 1 but stub phi=13 (dphi=3) -> no write; done at cycle 5; nmatch=0. Repeat with proj phi=13, stub phi=10 to check the signed direction.
3. nproj=3, nstub=4; every stub matches only projection 1 -> 4 writes {1,0}..{1,3} at consecutive addresses 0..3; done at cycle 1+3*5+2=18.
4. nproj=0 -> no reads consumed, no writes, done at cycle 3; second en_proc asserted while busy in scenario 3 -> ignored, single done.
5. ADDR_W=3 override, nproj=2, nstub=7, all pairs match -> 7 writes then saturation; overflow=1; nmatch=7; no write to address beyond 6.
6. reset asserted during SCAN of scenario 3 -> next cycle busy=0, match_wr_en=0, all outputs 0; fresh en_proc reproduces scenario 3 results exactly.
